sat_narrow_dlx: RTL and testbench

SAT_NARROW_DLX -- requirements
Module: sat_narrow_dlx

---
 rtl/sat_narrow_dlx.sv | 114 +++++++++++
 tb/tb_sat_narrow_dlx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_narrow_dlx.sv
// sat_narrow_dlx: two-stage narrowing pipeline for 32-bit signed values.
// S1 arithmetic-shifts the source right by in_shift into a 33-bit intermediate.
// S2 clamps that value to the selected 8/16-bit signed/unsigned range and
// re-extends it to 32 bits. A sticky counter records clamped output transfers.
// Build option: define SAT_NARROW_ROUND_EN to round half-up in S1. When it is
// left undefined, S1 truncates toward negative infinity.
module sat_narrow_dlx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_mode,
  input  logic [4:0]  in_shift,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sat,
  input  logic        clr_count,
  output logic [15:0] sat_count
);

  // Stage-1 state: the shifted value plus the mode it must be clamped with.
  logic               s1_valid;
  logic signed [32:0] s1_value;
  logic [1:0]         s1_mode;
  logic               s1_advance;

  // Shift datapath, computed on the incoming word.
  logic signed [32:0] in_ext;
  logic signed [32:0] in_shifted;

  // Per-mode clamp results. Mode n maps to index n.
  logic [3:0][31:0] clamp_val;
  logic [3:0]       clamp_low;
  logic [3:0]       clamp_high;

  // The output register frees up when it is empty or being drained.
  // S1 can then take a new word when it is empty or moving forward.
  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  // Sign-extend to 33 bits so the rounding bias can never overflow.
  assign in_ext = {in_data[31], in_data};

`ifdef SAT_NARROW_ROUND_EN
  logic signed [32:0] round_bias;
  // The half-LSB bias only applies when some bits are actually shifted out.
  assign round_bias = (in_shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (in_shift - 5'd1));
  assign in_shifted = (in_ext + round_bias) >>> in_shift;
`else
  assign in_shifted = in_ext >>> in_shift;
`endif

  // Clamp windows per mode.
  // The low 32 bits of a clamped 33-bit value are already its correct
  // sign-extended or zero-extended form, because every window fits in 32 bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_clamp
      localparam logic signed [32:0] LO = (gi == 0) ? -33'sd32768 :
                                          (gi == 1) ? -33'sd128   : 33'sd0;
      localparam logic signed [32:0] HI = (gi == 0) ? 33'sd32767 :
                                          (gi == 1) ? 33'sd127   :
                                          (gi == 2) ? 33'sd255   : 33'sd65535;
      assign clamp_low[gi]  = (s1_value < LO);
      assign clamp_high[gi] = (s1_value > HI);
      assign clamp_val[gi]  = clamp_low[gi]  ? LO[31:0] :
                              clamp_high[gi] ? HI[31:0] : s1_value[31:0];
    end
  endgenerate

  // S1 register: capture the shifted word whenever the stage can accept one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_mode  <= 2'b00;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_value <= in_shifted;
        s1_mode  <= in_mode;
      end
    end
  end

  // S2 register: load the clamped result. The output holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_sat   <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= clamp_val[s1_mode];
        out_sat  <= clamp_low[s1_mode] | clamp_high[s1_mode];
      end
    end
  end

  // Sticky saturation counter. A clear wins over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= 16'h0;
    end else if (clr_count) begin
      sat_count <= 16'h0;
    end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h1;
    end
  end

endmodule

// File: tb/tb_sat_narrow_dlx.sv
// tb_sat_narrow_dlx: randomized and directed bench for sat_narrow_dlx.
// Each accepted word is converted to its expected narrowed value using plain
// integer arithmetic. The result is queued in order and compared at the output.
// Honors SAT_NARROW_ROUND_EN the same way the design does.
module tb_sat_narrow_dlx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        clr_count;
  logic [15:0] sat_count;

  sat_narrow_dlx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .clr_count (clr_count),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        s;
    bit          vis;
  } ent_t;

  ent_t          q[$];
  logic [31:0]   got_q[$];
  int            exp_cnt;
  int            n_checks;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference narrowing: shift (with optional rounding), then clamp.
  task automatic narrow(input logic [31:0] d, input logic [1:0] m, input logic [4:0] s,
                        output logic [31:0] r, output logic sat);
    longint v;
    longint lo;
    longint hi;
    v = longint'($signed(d));
`ifdef SAT_NARROW_ROUND_EN
    if (s != 0) v = v + (longint'(1) << (s - 1));
`endif
    v = v >>> s;
    case (m)
      2'b00:   begin lo = -32768; hi = 32767; end
      2'b01:   begin lo = -128;   hi = 127;   end
      2'b10:   begin lo = 0;      hi = 255;   end
      default: begin lo = 0;      hi = 65535; end
    endcase
    sat = 1'b0;
    if (v < lo) begin v = lo; sat = 1'b1; end
    else if (v > hi) begin v = hi; sat = 1'b1; end
    r = v[31:0];
  endtask

  // The pipeline is full with a stalled output only when two words are held.
  function automatic logic model_in_ready();
    return (q.size() < 2) || out_ready;
  endfunction

  // Check this cycle's outputs, advance the model across one clock edge,
  // then return at the next falling edge.
  task automatic cycle();
    logic exp_ov;
    logic exp_ir;
    logic in_x;
    logic out_x;
    ent_t e;
    #1;
    exp_ov = (q.size() > 0) && q[0].vis;
    exp_ir = model_in_ready();
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    if (exp_ov) begin
      check("out_data", out_data, q[0].d);
      check("out_sat", {31'b0, out_sat}, {31'b0, q[0].s});
    end
    check("sat_count", {16'b0, sat_count}, exp_cnt[31:0]);
    in_x  = in_valid && exp_ir;
    out_x = exp_ov && out_ready;
    if (clr_count) exp_cnt = 0;
    else if (out_x && q[0].s && exp_cnt < 65535) exp_cnt++;
    if (out_x) begin
      got_q.push_back(q[0].d);
      void'(q.pop_front());
    end
    if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
    if (in_x) begin
      narrow(in_data, in_mode, in_shift, e.d, e.s);
      e.vis = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Push a single word through an idle pipeline. Check its result two edges
  // later, then drain it.
  task automatic send(input string tag, input logic [31:0] d, input logic [1:0] m,
                      input logic [4:0] s, input logic [31:0] ed, input logic es);
    in_valid = 1'b1; in_data = d; in_mode = m; in_shift = s; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_sat"}, {31'b0, out_sat}, {31'b0, es});
    $display("send %s: data=%h mode=%0d shift=%0d -> out=%h sat=%0d", tag, d, m, s, out_data, out_sat);
    cycle();
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = 32'($urandom_range(0, 600)) - 32'd300;
      2:       r = 32'($urandom_range(0, 140000)) - 32'd70000;
      default: r = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
    endcase
    return r;
  endfunction

  initial begin
    int idx;
    int guard;
    n_checks = 0; n_fail = 0; exp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_shift = '0;
    out_ready = 1'b0; clr_count = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_sat", {31'b0, out_sat}, 32'd0);
    check("rst_sat_count", {16'b0, sat_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Directed narrowing cases.
    send("s16_clamp", 32'h00012345, 2'b00, 5'd0, 32'h00007FFF, 1'b1);
    #1 check("s16_count", {16'b0, sat_count}, 32'd1);
    send("s8_clamp", 32'hFFFFFF00, 2'b01, 5'd0, 32'hFFFFFF80, 1'b1);
    send("u8_clamp", 32'hFFFFFFFF, 2'b10, 5'd0, 32'h00000000, 1'b1);
`ifdef SAT_NARROW_ROUND_EN
    send("rnd_pos", 32'h00000018, 2'b00, 5'd4, 32'h00000002, 1'b0);
    send("rnd_neg", 32'hFFFFFFE8, 2'b00, 5'd4, 32'hFFFFFFFF, 1'b0);
`else
    send("rnd_pos", 32'h00000018, 2'b00, 5'd4, 32'h00000001, 1'b0);
    send("rnd_neg", 32'hFFFFFFE8, 2'b00, 5'd4, 32'hFFFFFFFE, 1'b0);
`endif

    // Back-to-back stream against a stalled consumer.
    got_q.delete();
    idx = 1;
    in_mode = 2'b00; in_shift = 5'd0;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      out_ready = (c >= 4);
      in_valid  = (idx <= 4);
      in_data   = 32'(idx);
      if (c == 2) begin
        #1 check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      acc = model_in_ready();
      cycle();
      if (in_valid && acc) idx++;
    end
    in_valid = 1'b0;
    check("stream_len", got_q.size(), 32'd4);
    for (int i = 0; i < got_q.size(); i++) begin
      check("stream_order", got_q[i], 32'(i + 1));
      $display("stream out %0d: %h", i, got_q[i]);
    end

    // Reset with two words in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h00100000; in_mode = 2'b01;
    cycle();
    in_data = 32'h00000005;
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_sat_count", {16'b0, sat_count}, 32'd0);
    $display("async reset with 2 in flight: out_valid=%0d sat_count=%0d", out_valid, sat_count);
    q.delete(); exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) cycle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = rand_data();
      in_mode   = 2'($urandom_range(0, 3));
      in_shift  = 5'($urandom_range(0, 31));
      clr_count = ($urandom_range(0, 63) == 0);
      cycle();
    end
    in_valid = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    $display("random phase done: %0d checks so far", n_checks);

    // Drive the counter to its ceiling and past it.
    in_valid = 1'b1; in_data = 32'h00012345; in_mode = 2'b00; in_shift = 5'd0;
    guard = 0;
    while (exp_cnt < 65535 && guard < 70000) begin
      cycle();
      guard++;
    end
    check("sat_fill_bound", {31'b0, exp_cnt >= 65535}, 32'd1);
    in_valid = 1'b0;
    repeat (3) cycle();
    #1 check("sat_ceiling", {16'b0, sat_count}, 32'h0000FFFF);
    send("sat_extra", 32'h00012345, 2'b00, 5'd0, 32'h00007FFF, 1'b1);
    #1 check("sat_sticky", {16'b0, sat_count}, 32'h0000FFFF);

    // Clear together with a saturating output transfer.
    in_valid = 1'b1; in_data = 32'h80000000; in_mode = 2'b11; in_shift = 5'd0;
    cycle();
    in_valid = 1'b0;
    cycle();
    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0;
    #1 check("clr_priority", {16'b0, sat_count}, 32'd0);
    $display("clear with saturating transfer: sat_count=%0d", sat_count);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
